mem_arbiter: RTL
================

# mem_arbiter

Parametrised memory arbiter and backing store for the core's instruction and data ports. It accepts NUM_PORTS independent requesters, each using an enable/valid handshake, and grants one of them at a time. It serves byte, halfword and word accesses with correct byte-lane placement and sign/zero extension. A configurable access latency stands in for external-memory timing. It replaces the fixed two-port, word-only behavioural memory in front of the pipeline.

## Interface
- NUM_PORTS, 2: number of requesters. Port 0 is highest priority; by convention port 0 = data, port 1 = instr.
- ADDR_W, 25: byte-address width per port.
- DEPTH, 1024: number of 32-bit words in the store.
- LATENCY, 8: cycles from grant to valid; legal range 1..255.
- INIT_FILE, "": hex image loaded with $readmemh at elaboration if non-empty.

Ports (per-port fields are flattened, port p in slice p):
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- req  in  NUM_PORTS  access request; held high until that port's valid pulse.
- rw  in  NUM_PORTS  1 = write, 0 = read.
- oplen  in  2*NUM_PORTS  00 byte, 01 half, 10 word, 11 reserved.
- usgn  in  NUM_PORTS  1 = zero-extend read, 0 = sign-extend read.
- addr  in  ADDR_W*NUM_PORTS  byte address.
- wdata  in  32*NUM_PORTS  write data, right-aligned.
- valid  out  NUM_PORTS  one-cycle completion pulse.
- err  out  NUM_PORTS  qualifies valid; the access was rejected.
- rdata  out  32*NUM_PORTS  extended read data; stable from the valid cycle until the port's next valid.

## Operation
- FSM states:
  - IDLE: if any req is high, grant one port, latch its request fields, perform the access, go to WAIT.
  - WAIT: countdown from LATENCY-1; when the count reaches 0, go to RESP.
  - RESP: assert valid[grant] (and err if rejected), update rdata[grant], go to IDLE.
- Requests are sampled only in IDLE. req seen in RESP or in the cycle after valid is not a new request unless it is still high in IDLE.
- A requester must deassert req in the cycle after valid, or keep it high to issue a new access.
- Lane placement:
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0}+1 : {addr[1],0}.
  - word: all four lanes.
  - Writes touch only the addressed lanes.
  - Reads shift the addressed lanes down to bit 0, then extend according to usgn.
- Rejections (err=1, no store update, rdata=0):
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - oplen=11;
  - word index addr[ADDR_W-1:2] ≥ DEPTH.
- Write responses return rdata=0.

## Timing
- Reset values: valid=0, err=0, rdata=0 for all ports, FSM=IDLE, round-robin pointer=0. Store contents are not affected by reset.
- Reset asserted mid-access aborts it. No valid is produced, and a write already committed at grant stays committed.
- Request with req high in IDLE at cycle t:
  - grant edge at end of t;
  - valid high during cycle t+LATENCY+1 (RESP);
  - next grant no earlier than edge t+LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- Simultaneous requests: the arbitration policy (see Configuration) picks one port. Losers keep req high and are served later; no request is dropped.
- Write then read of the same word from different ports: the read returns the new data (the write commits at its grant edge).

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. The pointer advances to grant+1 (mod NUM_PORTS) after each grant, and the search starts at the pointer.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins. Port 0 can starve higher-indexed ports.

## Test plan
- Word write then read, LATENCY=8: port 0 writes 0xDEADBEEF at 0x10, then reads 0x10 → valid in cycle t+9 of each access, rdata=0xDEADBEEF, err=0.
- Sub-word read of word 0x80FF7F01 at 0x20:
  - byte at 0x23, signed → 0xFFFFFF80;
  - byte at 0x21, unsigned → 0x0000007F;
  - half at 0x22, signed → 0xFFFF80FF.
- Byte write of 0xAB to 0x21 over 0x11223344 → word reads 0x1122AB44.
- Rejections:
  - half at 0x21 → err=1, rdata=0, store unchanged;
  - word at 0x4*DEPTH → err=1.
- Contention: ports 0 and 1 request in the same cycle with req held high.
  - Without MEM_ARB_RR_EN: port 0 is served first, and port 1 is served only once port 0 drops req.
  - With MEM_ARB_RR_EN and both held high: grants alternate 0,1,0,1.
- Reset: rst asserted during WAIT → no valid, FSM=IDLE next cycle, and a subsequent request completes normally after LATENCY+1 cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the memory requesters and mem_arbiter.
// Per-port fields are flattened: port p occupies slice p of every vector.
interface mem_arbiter_if #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 25
);
   logic [NUM_PORTS-1:0]        req;
   logic [NUM_PORTS-1:0]        rw;
   logic [2*NUM_PORTS-1:0]      oplen;
   logic [NUM_PORTS-1:0]        usgn;
   logic [ADDR_W*NUM_PORTS-1:0] addr;
   logic [32*NUM_PORTS-1:0]     wdata;
   logic [NUM_PORTS-1:0]        valid;
   logic [NUM_PORTS-1:0]        err;
   logic [32*NUM_PORTS-1:0]     rdata;

   // Requester side: drives the access, receives the completion.
   modport master (
      output req, rw, oplen, usgn, addr, wdata,
      input  valid, err, rdata
   );

   // Arbiter side.
   modport slave (
      input  req, rw, oplen, usgn, addr, wdata,
      output valid, err, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: NUM_PORTS-way arbiter in front of a DEPTH x 32-bit store with
// byte/half/word accesses, sign/zero extension and a fixed LATENCY from grant
// to the one-cycle valid pulse. The access (write commit or read capture)
// happens at the grant edge; the response is only delayed.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest port index winning.
module mem_arbiter #(
  parameter int    NUM_PORTS = 2,
  parameter int    ADDR_W    = 25,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 8,
  parameter string INIT_FILE = ""
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Sign/zero extension of a right-aligned read value.
  function automatic logic [31:0] read_extend(input logic [31:0] v,
                                              input logic [1:0]  len,
                                              input logic        us);
    logic [31:0] r;
    case (len)
      2'b00:   r = us ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   r = us ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Expand a 4-bit lane enable into a 32-bit bit mask.
  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*i +: 8] = {8{m[i]}};
    return b;
  endfunction

  // First requesting port found when searching upward from 'start' (wrapping).
  function automatic logic [PW-1:0] arb_pick(input logic [NUM_PORTS-1:0] r,
                                             input logic [PW-1:0]        start);
    logic [PW-1:0] p;
    p = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (r[(int'(start) + k) % NUM_PORTS]) p = PW'((int'(start) + k) % NUM_PORTS);
    end
    return p;
  endfunction

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [PW-1:0]           gnt_q, gnt_d;
  logic [31:0]             res_q, res_d;
  logic                    rej_q, rej_d;
  logic [NUM_PORTS-1:0]    valid_q, valid_d;
  logic [NUM_PORTS-1:0]    err_q, err_d;
  logic [32*NUM_PORTS-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_RR_EN
  logic [PW-1:0]           rr_q, rr_d;
`endif

  logic [31:0] mem_q [DEPTH];

  logic                any_req;
  logic [PW-1:0]       pick;
  logic                a_rw;
  logic                a_usgn;
  logic [1:0]          a_len;
  logic [ADDR_W-1:0]   a_addr;
  logic [31:0]         a_wdata;
  logic [31:0]         a_word;
  logic [4:0]          a_sh;
  logic [3:0]          a_mask;
  logic [31:0]         a_bits;
  logic [31:0]         a_merged;
  logic                a_rej;
  logic [31:0]         a_res;
  logic                a_commit;

  // Choose the port to grant and decode its access against the store.
  always_comb begin
    any_req = |bus.req;
`ifdef MEM_ARB_RR_EN
    pick    = arb_pick(bus.req, rr_q);
`else
    pick    = arb_pick(bus.req, '0);
`endif
    a_rw    = bus.rw[pick];
    a_usgn  = bus.usgn[pick];
    a_len   = bus.oplen[2*int'(pick) +: 2];
    a_addr  = bus.addr[ADDR_W*int'(pick) +: ADDR_W];
    a_wdata = bus.wdata[32*int'(pick) +: 32];
    a_word  = mem_q[a_addr[AW+1:2]];
    a_sh    = {a_addr[1:0], 3'b000};
    a_rej   = (a_len == 2'b11)
            | ((a_len == 2'b01) & a_addr[0])
            | ((a_len == 2'b10) & (a_addr[1:0] != 2'b00))
            | (32'(a_addr[ADDR_W-1:2]) >= 32'(DEPTH));
    case (a_len)
      2'b00:   a_mask = 4'b0001 << a_addr[1:0];
      2'b01:   a_mask = 4'b0011 << {a_addr[1], 1'b0};
      default: a_mask = 4'b1111;
    endcase
    a_bits   = lane_bits(a_mask);
    a_merged = (a_word & ~a_bits) | ((a_wdata << a_sh) & a_bits);
    a_res    = (a_rw | a_rej) ? 32'd0 : read_extend(a_word >> a_sh, a_len, a_usgn);
    a_commit = (state_q == S_IDLE) & any_req & a_rw & ~a_rej & ~rst;
  end

  // Next-state logic for the grant/wait/respond sequence and its outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    res_d   = res_q;
    rej_d   = rej_q;
    valid_d = '0;
    err_d   = '0;
    rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          res_d   = a_res;
          rej_d   = a_rej;
          cnt_d   = 8'(LATENCY - 1);
          state_d = S_WAIT;
`ifdef MEM_ARB_RR_EN
          rr_d    = (int'(pick) == NUM_PORTS - 1) ? '0 : pick + 1'b1;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d                       = S_RESP;
          valid_d[gnt_q]                = 1'b1;
          err_d[gnt_q]                  = rej_q;
          rdata_d[32*int'(gnt_q) +: 32] = res_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Per-access payload captured at grant; only meaningful while not idle.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    gnt_q <= gnt_d;
    res_q <= res_d;
    rej_q <= rej_d;
  end

  // Writes commit at the grant edge, touching only the addressed lanes.
  always_ff @(posedge clk) begin
    if (a_commit) mem_q[a_addr[AW+1:2]] <= a_merged;
  end

  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule
